// File: rtl/trigger_capture_buffer_pkg.sv
// Shared definitions for the trigger capture buffer and its display reader:
// capture FSM states and the time-index to physical-address helper.
package trigger_capture_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      PREFILL   = 3'd1,
      WAIT_TRIG = 3'd2,
      POSTFILL  = 3'd3,
      DONE      = 3'd4
   } state_t;

   // Oldest frame sample sits PRETRIGGER slots before the trigger; wrap is modulo 2**abits.
   function automatic logic [31:0] frame_to_phys(input logic [31:0] trig,
                                                 input logic [31:0] pre,
                                                 input logic [31:0] idx,
                                                 input int unsigned abits);
      logic [31:0] mask;
      mask = (32'd1 << abits) - 32'd1;
      return (trig - pre + idx) & mask;
   endfunction

endpackage

// File: rtl/trigger_capture_buffer_if.sv
// Sample, trigger-control and readout signals of the capture buffer.
interface trigger_capture_buffer_if #(
   parameter int DATA_BITS = 12,
   parameter int ADDR_BITS = 10
);
   logic                 dataReady;
   logic [DATA_BITS-1:0] dataIn;
   logic                 isTriggered;
   logic                 arm;
   logic                 triggerDisable;
   logic                 captureDone;
   logic                 readEn;
   logic [ADDR_BITS-1:0] readAddr;
   logic [DATA_BITS-1:0] readData;
   logic                 readValid;
   logic                 autoTriggered;

   modport master (
      output dataReady, dataIn, isTriggered, arm, readEn, readAddr,
      input  triggerDisable, captureDone, readData, readValid, autoTriggered
   );

   modport slave (
      input  dataReady, dataIn, isTriggered, arm, readEn, readAddr,
      output triggerDisable, captureDone, readData, readValid, autoTriggered
   );
endinterface

// File: rtl/trigger_capture_buffer_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port.
module capture_ram #(
   parameter int DATA_BITS = 12,
   parameter int ADDR_BITS = 10
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 we,
   input  logic [ADDR_BITS-1:0] waddr,
   input  logic [DATA_BITS-1:0] wdata,
   input  logic                 re,
   input  logic [ADDR_BITS-1:0] raddr,
   output logic [DATA_BITS-1:0] rdata
);
   logic [DATA_BITS-1:0] mem [2**ADDR_BITS];

   always_ff @(posedge clock) begin
      if (we) mem[waddr] <= wdata;
   end

   // Only the output register is reset; storage stays reset-free so it maps to block RAM.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)  rdata <= '0;
      else if (re)   rdata <= mem[raddr];
   end
endmodule

// File: rtl/trigger_capture_buffer.sv
// Circular sample recorder frozen around a trigger, read back in time order.
// Optional timeout trigger: define TRIGGER_CAPTURE_AUTO_TRIGGER_EN.
module trigger_capture_buffer
   import trigger_capture_pkg::*;
#(
   parameter int DATA_BITS    = 12,
   parameter int ADDR_BITS    = 10,
   parameter int PRETRIGGER   = 256,
   parameter int AUTO_TIMEOUT = 4096
) (
   input logic                     clock,
   input logic                     reset_n,
   trigger_capture_buffer_if.slave bus
);
   localparam int DEPTH = 1 << ADDR_BITS;
   localparam int NPOST = DEPTH - PRETRIGGER - 1;
   typedef logic [ADDR_BITS-1:0] addr_t;
   localparam addr_t FILL_LAST = addr_t'(PRETRIGGER - 1);
   localparam addr_t POST_LAST = addr_t'(NPOST - 2);

   if (PRETRIGGER < 1 || PRETRIGGER > DEPTH - 1 || AUTO_TIMEOUT < 1) begin : g_bad_cfg
      $error("trigger_capture_buffer: parameter out of range");
   end

   state_t state, state_nx;
   addr_t  wr_ptr, fill_cnt, post_cnt, trig_addr, rd_addr;
   logic   wr_en, trig_hit, auto_hit, arm_ok, rd_ok, rd_valid;

   assign arm_ok = bus.arm && (state == IDLE || state == DONE);

   always_comb begin
      state_nx = state;
      wr_en    = 1'b0;
      trig_hit = 1'b0;
      case (state)
         IDLE, DONE: if (bus.arm) state_nx = PREFILL;
         PREFILL: if (bus.dataReady) begin
            wr_en = 1'b1;
            if (fill_cnt == FILL_LAST) state_nx = WAIT_TRIG;
         end
         WAIT_TRIG: if (bus.dataReady) begin
            wr_en    = 1'b1;
            trig_hit = bus.isTriggered || auto_hit;
            // The trigger-cycle write is already post sample 1.
            if (trig_hit) state_nx = (NPOST < 2) ? DONE : POSTFILL;
         end
         POSTFILL: if (bus.dataReady) begin
            wr_en = 1'b1;
            if (post_cnt == POST_LAST) state_nx = DONE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         wr_ptr    <= '0;
         fill_cnt  <= '0;
         post_cnt  <= '0;
         trig_addr <= '0;
         rd_valid  <= 1'b0;
      end else begin
         state    <= state_nx;
         rd_valid <= rd_ok;
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (arm_ok)                                  fill_cnt <= '0;
         else if (state == PREFILL && bus.dataReady)  fill_cnt <= fill_cnt + 1'b1;
         // isTriggered arrives one strobe late, so the trigger sample is the previous write.
         if (trig_hit) begin
            trig_addr <= wr_ptr - 1'b1;
            post_cnt  <= '0;
         end else if (state == POSTFILL && bus.dataReady) begin
            post_cnt <= post_cnt + 1'b1;
         end
      end
   end

`ifdef TRIGGER_CAPTURE_AUTO_TRIGGER_EN
   localparam int AW = $clog2(AUTO_TIMEOUT + 1);
   logic [AW-1:0] auto_cnt;
   logic          auto_flag;

   assign auto_hit = (state == WAIT_TRIG) && bus.dataReady && (auto_cnt == AW'(AUTO_TIMEOUT - 1));

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         auto_cnt  <= '0;
         auto_flag <= 1'b0;
      end else if (arm_ok) begin
         auto_cnt  <= '0;
         auto_flag <= 1'b0;
      end else if (state == WAIT_TRIG && bus.dataReady) begin
         auto_cnt <= auto_cnt + 1'b1;
         if (auto_hit && !bus.isTriggered) auto_flag <= 1'b1;
      end
   end

   assign bus.autoTriggered = auto_flag;
`else
   assign auto_hit          = 1'b0;
   assign bus.autoTriggered = 1'b0;
`endif

   assign bus.triggerDisable = (state != WAIT_TRIG);
   assign bus.captureDone    = (state == DONE);
   assign bus.readValid      = rd_valid;
   assign rd_ok   = bus.readEn && (state == DONE);
   assign rd_addr = ADDR_BITS'(frame_to_phys(32'(trig_addr), 32'(PRETRIGGER),
                                             32'(bus.readAddr), ADDR_BITS));

   capture_ram #(.DATA_BITS(DATA_BITS), .ADDR_BITS(ADDR_BITS)) u_ram (
      .clock   (clock),
      .reset_n (reset_n),
      .we      (wr_en),
      .waddr   (wr_ptr),
      .wdata   (bus.dataIn),
      .re      (rd_ok),
      .raddr   (rd_addr),
      .rdata   (bus.readData)
   );
endmodule

// File: tb/tb_trigger_capture_buffer.sv
// Randomized bench for trigger_capture_buffer; a frame is modelled as the last DEPTH
// written samples, with trigger/done timing derived from sample counts since arm.
module tb_trigger_capture_buffer;
   localparam int DATA_BITS = 12;
   localparam int ADDR_BITS = 4;
   localparam int DEPTH     = 16;
   localparam int PRE       = 4;
   localparam int AUTO_TO   = 8;
   localparam int NPOST     = DEPTH - PRE - 1;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   trigger_capture_buffer_if #(.DATA_BITS(DATA_BITS), .ADDR_BITS(ADDR_BITS)) bus();

   trigger_capture_buffer #(
      .DATA_BITS(DATA_BITS), .ADDR_BITS(ADDR_BITS),
      .PRETRIGGER(PRE), .AUTO_TIMEOUT(AUTO_TO)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // reference model
   bit m_armed, m_done, m_trig, m_auto;
   int m_nw, m_wait, m_npost;
   logic [DATA_BITS-1:0] hist[$];
   logic [DATA_BITS-1:0] m_trig_val, m_rdata;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic bit m_waiting();
      return m_armed && !m_done && !m_trig && (m_nw >= PRE);
   endfunction

   function automatic logic [DATA_BITS-1:0] frame_at(input int a);
      return hist[hist.size() - DEPTH + a];
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic m_rearm();
      m_armed = 1; m_done = 0; m_trig = 0; m_auto = 0;
      m_nw = 0; m_wait = 0; m_npost = 0;
   endtask

   task automatic strobe(input logic [DATA_BITS-1:0] v, input bit t);
      bit fire;
      repeat ($urandom_range(0, 2)) tick();
      bus.dataReady = 1'b1; bus.dataIn = v; bus.isTriggered = t;
      if (m_armed && !m_done) begin
         if (m_waiting()) begin
            fire = t;
`ifdef TRIGGER_CAPTURE_AUTO_TRIGGER_EN
            if (!t && m_wait == AUTO_TO - 1) begin fire = 1; m_auto = 1; end
`endif
            if (fire) begin
               m_trig = 1; m_trig_val = hist[$]; m_npost = 1;
               m_done = (m_npost >= NPOST);
            end else begin
               m_wait++;
            end
         end else if (m_trig) begin
            m_npost++;
            m_done = (m_npost >= NPOST);
         end
         hist.push_back(v);
         m_nw++;
         if (hist.size() > 64) void'(hist.pop_front());
      end
      tick();
      bus.dataReady = 1'b0; bus.isTriggered = 1'b0;
      chk("trig_disable", bus.triggerDisable, !m_waiting());
      chk("capture_done", bus.captureDone, m_done);
      chk("auto_trig", bus.autoTriggered, m_auto);
   endtask

   task automatic do_arm();
      bus.arm = 1'b1; tick(); bus.arm = 1'b0;
      if (!m_armed || m_done) m_rearm();
      chk("arm_done", bus.captureDone, m_done);
   endtask

   task automatic do_read(input int a);
      logic [DATA_BITS-1:0] exp;
      bit ok;
      ok  = m_done;
      exp = ok ? frame_at(a) : m_rdata;
      bus.readEn = 1'b1; bus.readAddr = ADDR_BITS'(a);
      tick();
      bus.readEn = 1'b0;
      chk("rd_valid", bus.readValid, ok);
      chk("rd_data", bus.readData, exp);
      m_rdata = exp;
   endtask

   task automatic read_frame();
      for (int a = 0; a < DEPTH; a++) do_read(a);
      tick();
      chk("rd_pulse_end", bus.readValid, 0);
      do_read(PRE);
      chk("trig_sample", bus.readData, m_trig_val);
   endtask

   task automatic read_arm(input int a);
      logic [DATA_BITS-1:0] exp;
      exp = frame_at(a);
      bus.readEn = 1'b1; bus.readAddr = ADDR_BITS'(a); bus.arm = 1'b1;
      tick();
      bus.readEn = 1'b0; bus.arm = 1'b0;
      chk("ra_valid", bus.readValid, 1);
      chk("ra_data", bus.readData, exp);
      m_rdata = exp;
      m_rearm();
      chk("ra_done_drop", bus.captureDone, m_done);
   endtask

   // wait_n >= 1 keeps every frame made of at least DEPTH writes since arm or reset.
   task automatic run_frame(input int wait_n, input bit noise, input bit ramp, input bit arm_first);
      int n;
      logic [DATA_BITS-1:0] v;
      bit t;
      n = 0; v = '0;
      if (arm_first) do_arm();
      while (!m_done && n < 300) begin
         if (m_waiting()) t = (m_wait >= wait_n);
         else             t = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         strobe(ramp ? v : DATA_BITS'($urandom), t);
         v++; n++;
         if (noise && !m_done && $urandom_range(0, 5) == 0) do_arm();
      end
      chk("frame_done", bus.captureDone, 1);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_trig_dis"}, bus.triggerDisable, 1);
      chk({tag, "_done"}, bus.captureDone, 0);
      chk({tag, "_rd_valid"}, bus.readValid, 0);
      chk({tag, "_rd_data"}, bus.readData, 0);
      chk({tag, "_auto"}, bus.autoTriggered, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.dataReady = 1'b0; bus.dataIn = '0; bus.isTriggered = 1'b0;
      bus.arm = 1'b0; bus.readEn = 1'b0; bus.readAddr = '0;
      m_armed = 0; m_done = 0; m_trig = 0; m_auto = 0;
      m_nw = 0; m_wait = 0; m_npost = 0; m_rdata = '0; m_trig_val = '0;

      reset_n = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      chk_reset_outputs("reset");
      reset_n = 1'b1;
      tick();

      do_read(3);                       // not captured: no valid, data held

      // ramp frame, isTriggered arrives with sample 10 -> trigger sample is 9
      run_frame(6, 0, 1, 1);
      do_read(4);
      chk("basic_trig_val", bus.readData, 9);
      do_read(0);
      chk("basic_oldest", bus.readData, 5);
      read_frame();

      run_frame(30, 0, 0, 1);           // long wait: physical indices wrap
      read_frame();

      for (int k = 0; k < 3; k++) begin
         run_frame($urandom_range(1, 5), 1, 0, 1);
         read_frame();
      end

      read_arm(3);
      run_frame(3, 1, 0, 0);
      read_frame();

      // asynchronous reset in the middle of POSTFILL
      do_arm();
      for (int i = 0; i < 100 && !(m_trig && m_npost >= 3); i++)
         strobe(DATA_BITS'($urandom), m_waiting() && m_wait >= 2);
      #2 reset_n = 1'b0;
      #1;
      chk_reset_outputs("mid_reset");
      m_armed = 0; m_done = 0; m_trig = 0; m_auto = 0; m_rdata = '0;
      @(negedge clock);
      reset_n = 1'b1;
      tick();
      run_frame(4, 1, 0, 1);
      read_frame();

      run_frame(12, 0, 0, 1);           // past the timeout
      read_frame();
      run_frame(AUTO_TO - 1, 0, 0, 1);  // real trigger on the timeout strobe
      read_frame();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
